// File: rtl/fb_write_arbiter.sv
// Write-port controller for the 160x120 RGB444 frame buffer: arbitrates between a
// single-pixel port and a rectangle-fill engine, and drives the RAM write port.
module fb_write_arbiter #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          px_valid,
    input  logic [XW-1:0] px_x,
    input  logic [YW-1:0] px_y,
    input  logic [DW-1:0] px_color,
    output logic          px_ready,
    input  logic          fill_start,
    input  logic [XW-1:0] fill_x0,
    input  logic [YW-1:0] fill_y0,
    input  logic [XW-1:0] fill_x1,
    input  logic [YW-1:0] fill_y1,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_en
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    fill_state_t   state;
    logic [XW-1:0] x0_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [DW-1:0] color_q;
    logic          last_px;

    logic [XW-1:0] clamp_x0;
    logic [XW-1:0] clamp_x1;
    logic [YW-1:0] clamp_y0;
    logic [YW-1:0] clamp_y1;
    logic          fill_active;
    logic          fill_grant;
    logic          px_grant;
    logic          px_in_range;

    function automatic logic [AW-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(y) * AW'(H_RES) + AW'(x);
    endfunction

    // Rectangle corners are clamped to the visible area before any ordering check.
    always_comb begin
        clamp_x0 = (fill_x0 > X_MAX) ? X_MAX : fill_x0;
        clamp_x1 = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
        clamp_y0 = (fill_y0 > Y_MAX) ? Y_MAX : fill_y0;
        clamp_y1 = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
    end

    // Under contention last_px says the pixel port won last time, so the fill engine goes next.
    always_comb begin
        fill_active = (state == FILL);
        fill_grant  = fill_active && (!px_valid || last_px);
        px_grant    = px_valid && !fill_grant;
        px_ready    = !reset && !fill_grant;
        px_in_range = (px_x <= X_MAX) && (px_y <= Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_px <= 1'b0;
        end else if (px_valid && fill_active) begin
            last_px <= !last_px;
        end
    end

    // Single registered write stage: a grant this cycle becomes a RAM write next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (fill_grant) begin
            wr_en   <= 1'b1;
            wr_addr <= lin_addr(cur_x, cur_y);
            wr_data <= color_q;
        end else if (px_grant && px_in_range) begin
            wr_en   <= 1'b1;
            wr_addr <= lin_addr(px_x, px_y);
            wr_data <= px_color;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Fill engine walks the rectangle in raster order, advancing only on granted cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            color_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_done <= 1'b0;
                    if (fill_start) begin
                        x0_q    <= clamp_x0;
                        x1_q    <= clamp_x1;
                        y1_q    <= clamp_y1;
                        cur_x   <= clamp_x0;
                        cur_y   <= clamp_y0;
                        color_q <= fill_color;
                        if ((clamp_x0 > clamp_x1) || (clamp_y0 > clamp_y1)) begin
                            state     <= DONE;
                            fill_done <= 1'b1;
                        end else begin
                            state     <= FILL;
                            fill_busy <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_grant) begin
                        if (cur_x == x1_q) begin
                            if (cur_y == y1_q) begin
                                state     <= DONE;
                                fill_busy <= 1'b0;
                                fill_done <= 1'b1;
                            end else begin
                                cur_x <= x0_q;
                                cur_y <= cur_y + 1'b1;
                            end
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    fill_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: a scoreboard of expected RAM writes is
// filled as grants are driven and drained by a monitor on the write port.
module tb_fb_write_arbiter;

    typedef struct packed {
        logic [14:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        px_valid;
    logic [7:0]  px_x;
    logic [6:0]  px_y;
    logic [11:0] px_color;
    logic        px_ready;
    logic        fill_start;
    logic [7:0]  fill_x0;
    logic [6:0]  fill_y0;
    logic [7:0]  fill_x1;
    logic [6:0]  fill_y1;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];
    wr_t mon_exp;

    fb_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .px_valid  (px_valid),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .px_ready  (px_ready),
        .fill_start(fill_start),
        .fill_x0   (fill_x0),
        .fill_y0   (fill_y0),
        .fill_x1   (fill_x1),
        .fill_y1   (fill_y1),
        .fill_color(fill_color),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every RAM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("[TB] FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wr_addr !== mon_exp.addr || wr_data !== mon_exp.data) begin
                    failures = failures + 1;
                    $display("[TB] FAIL write_value got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    function automatic wr_t mk(input int addr, input logic [11:0] data);
        wr_t w;
        w.addr = 15'(addr);
        w.data = data;
        return w;
    endfunction

    task automatic run_fill(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1,
                            input logic [6:0] y1, input logic [11:0] color,
                            output int busy_cnt, output int wr_cnt, output int cycles,
                            output logic done_seen, output logic done_wr);
        @(negedge clk);
        fill_x0 = x0; fill_y0 = y0; fill_x1 = x1; fill_y1 = y1; fill_color = color;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        busy_cnt = 0; wr_cnt = 0; cycles = 0; done_seen = 1'b0; done_wr = 1'b0;
        for (int i = 0; i < 20000 && !done_seen; i++) begin
            if (fill_busy === 1'b1) busy_cnt++;
            if (wr_en === 1'b1) wr_cnt++;
            if (fill_done === 1'b1) begin
                done_seen = 1'b1;
                done_wr   = wr_en;
                cycles    = i;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if ({wr_en, wr_addr, wr_data, fill_busy, fill_done, px_ready} !== 31'd0) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_state got en=%b addr=%0d data=%h busy=%b done=%b ready=%b required all zero",
                     wr_en, wr_addr, wr_data, fill_busy, fill_done, px_ready);
        end
        reset = 1'b0;
        #1;
        checks = checks + 1;
        if (px_ready !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL ready_after_reset got %b required 1", px_ready);
        end
    endtask

    task automatic test_pixel();
        @(negedge clk);
        px_valid = 1'b1; px_x = 8'd10; px_y = 7'd5; px_color = 12'hF00;
        #1;
        checks = checks + 1;
        if (px_ready !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL pixel_ready got %b required 1", px_ready);
        end
        exp_q.push_back(mk(810, 12'hF00));
        @(negedge clk);
        px_valid = 1'b0;
        checks = checks + 1;
        if (wr_en !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL pixel_latency wr_en got %b required 1", wr_en);
        end
        @(negedge clk);
        checks = checks + 1;
        if (wr_en !== 1'b0 || wr_addr !== 15'd810 || wr_data !== 12'hF00) begin
            failures = failures + 1;
            $display("[TB] FAIL pixel_hold got en=%b addr=%0d data=%h required en=0 addr=810 data=f00",
                     wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        px_valid = 1'b1; px_x = 8'd160; px_y = 7'd0; px_color = 12'hABC;
        #1;
        checks = checks + 1;
        if (px_ready !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL oor_x_ready got %b required 1", px_ready);
        end
        @(negedge clk);
        px_x = 8'd0; px_y = 7'd120;
        #1;
        checks = checks + 1;
        if (px_ready !== 1'b1 || wr_en !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL oor_x_write got ready=%b wr_en=%b required ready=1 wr_en=0", px_ready, wr_en);
        end
        @(negedge clk);
        px_valid = 1'b0;
        checks = checks + 1;
        if (wr_en !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL oor_y_write wr_en got %b required 0", wr_en);
        end
    endtask

    task automatic test_full_fill();
        int busy_cnt, wr_cnt, cycles;
        logic done_seen, done_wr;
        for (int a = 0; a < 19200; a++) exp_q.push_back(mk(a, 12'h000));
        run_fill(8'd0, 7'd0, 8'd159, 7'd119, 12'h000, busy_cnt, wr_cnt, cycles, done_seen, done_wr);
        checks = checks + 1;
        if (!done_seen || !done_wr || fill_busy !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL full_fill_done got done=%b wr_at_done=%b busy=%b required 1 1 0",
                     done_seen, done_wr, fill_busy);
        end
        checks = checks + 1;
        if (busy_cnt != 19200 || wr_cnt != 19200) begin
            failures = failures + 1;
            $display("[TB] FAIL full_fill_counts got busy=%0d writes=%0d required 19200 19200", busy_cnt, wr_cnt);
        end
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0 || fill_done !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL full_fill_drain got pending=%0d done=%b required 0 0", exp_q.size(), fill_done);
        end
    endtask

    task automatic test_contended();
        logic exp_ready;
        @(negedge clk);
        px_valid = 1'b1; px_x = 8'd0; px_y = 7'd0; px_color = 12'hFFF;
        fill_x0 = 8'd2; fill_y0 = 7'd3; fill_x1 = 8'd5; fill_y1 = 7'd3; fill_color = 12'h0F0;
        fill_start = 1'b1;
        exp_q.push_back(mk(0, 12'hFFF));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            fill_start = 1'b0;
            #1;
            exp_ready = (k % 2 == 0);
            checks = checks + 1;
            if (px_ready !== exp_ready || fill_busy !== 1'b1) begin
                failures = failures + 1;
                $display("[TB] FAIL alternate_grant k=%0d got ready=%b busy=%b required ready=%b busy=1",
                         k, px_ready, fill_busy, exp_ready);
            end
            if (exp_ready) exp_q.push_back(mk(0, 12'hFFF));
            else exp_q.push_back(mk(482 + k / 2, 12'h0F0));
        end
        @(negedge clk);
        checks = checks + 1;
        if (fill_done !== 1'b1 || wr_en !== 1'b1 || fill_busy !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL contended_done got done=%b wr_en=%b busy=%b required 1 1 0",
                     fill_done, wr_en, fill_busy);
        end
        px_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL contended_drain pending got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_clamp_and_empty();
        int busy_cnt, wr_cnt, cycles;
        logic done_seen, done_wr;
        exp_q.push_back(mk(19199, 12'h5A5));
        run_fill(8'd200, 7'd125, 8'd255, 7'd127, 12'h5A5, busy_cnt, wr_cnt, cycles, done_seen, done_wr);
        checks = checks + 1;
        if (!done_seen || !done_wr || wr_cnt != 1 || busy_cnt != 1) begin
            failures = failures + 1;
            $display("[TB] FAIL clamp_fill got done=%b wr_at_done=%b writes=%0d busy=%0d required 1 1 1 1",
                     done_seen, done_wr, wr_cnt, busy_cnt);
        end
        run_fill(8'd5, 7'd0, 8'd2, 7'd0, 12'h777, busy_cnt, wr_cnt, cycles, done_seen, done_wr);
        checks = checks + 1;
        if (!done_seen || cycles != 0 || wr_cnt != 0 || busy_cnt != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL empty_fill got done=%b delay=%0d writes=%0d busy=%0d required 1 0 0 0",
                     done_seen, cycles, wr_cnt, busy_cnt);
        end
        @(negedge clk);
        checks = checks + 1;
        if (fill_done !== 1'b0 || wr_en !== 1'b0 || exp_q.size() != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL empty_fill_after got done=%b wr_en=%b pending=%0d required 0 0 0",
                     fill_done, wr_en, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        int busy_cnt, wr_cnt, cycles;
        logic done_seen, done_wr;
        @(negedge clk);
        fill_x0 = 8'd0; fill_y0 = 7'd0; fill_x1 = 8'd159; fill_y1 = 7'd119; fill_color = 12'h123;
        fill_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            fill_start = 1'b0;
            if (i == 2) begin
                fill_x0 = 8'd10; fill_y0 = 7'd10; fill_x1 = 8'd20; fill_y1 = 7'd20; fill_color = 12'hEEE;
                fill_start = 1'b1;
            end
            exp_q.push_back(mk(i, 12'h123));
        end
        @(negedge clk);
        fill_start = 1'b0;
        reset = 1'b1;
        #1;
        checks = checks + 1;
        if (px_ready !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL ready_in_reset got %b required 0", px_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        checks = checks + 1;
        if (fill_busy !== 1'b0 || fill_done !== 1'b0 || wr_en !== 1'b0 || exp_q.size() != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL after_reset got busy=%b done=%b wr_en=%b pending=%0d required 0 0 0 0",
                     fill_busy, fill_done, wr_en, exp_q.size());
        end
        @(negedge clk);
        checks = checks + 1;
        if (fill_done !== 1'b0 || wr_en !== 1'b0) begin
            failures = failures + 1;
            $display("[TB] FAIL no_done_after_reset got done=%b wr_en=%b required 0 0", fill_done, wr_en);
        end
        exp_q.push_back(mk(161, 12'h3C3));
        exp_q.push_back(mk(162, 12'h3C3));
        run_fill(8'd1, 7'd1, 8'd2, 7'd1, 12'h3C3, busy_cnt, wr_cnt, cycles, done_seen, done_wr);
        checks = checks + 1;
        if (!done_seen || !done_wr || wr_cnt != 2 || busy_cnt != 2) begin
            failures = failures + 1;
            $display("[TB] FAIL refill_after_reset got done=%b wr_at_done=%b writes=%0d busy=%0d required 1 1 2 2",
                     done_seen, done_wr, wr_cnt, busy_cnt);
        end
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("[TB] FAIL final_drain pending got %0d required 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1; px_valid = 1'b0; px_x = '0; px_y = '0; px_color = '0;
        fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_x1 = '0; fill_y1 = '0; fill_color = '0;
        test_reset();
        test_pixel();
        test_out_of_range();
        test_full_fill();
        test_contended();
        test_clamp_and_empty();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
